// File: rtl/falafel_pkg.sv
// Shared types for the falafel request path: entry payload and merged-request op tag.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package falafel_pkg;

  localparam int MSG_ID_SIZE = 8;
  localparam int DATA_W      = 16;

  typedef struct packed {
    logic [MSG_ID_SIZE-1:0] id;
    logic [DATA_W-1:0]      size;
  } alloc_entry_t;

  typedef enum logic {
    OP_ALLOC = 1'b0,
    OP_FREE  = 1'b1
  } req_op_e;

endpackage

// File: rtl/falafel_fifo.sv
// Generic synchronous FIFO, DEPTH entries of payload type T, head shown combinationally.
// Latency: a pushed entry is at head one cycle later when the FIFO was empty.
// Backpressure: push ignored while full (even with a same-cycle pop); pop ignored while empty.
//
// Ports: clk_i/rst_ni clock and async active-low reset; push/din write side;
//        pop/head read side; full/empty/cnt registered occupancy status.
module falafel_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0],
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push,
  input  T              din,
  input  logic          pop,
  output T              head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] cnt
);

  T              mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  // Status comes only from registered count, so no input reaches full/empty.
  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage carries no reset; validity is tracked by cnt.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  // DEPTH is a power of two, so pointers wrap naturally at PW bits.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/falafel_req_arbiter.sv
// Queues alloc/free entries in two FIFOs and merges them round-robin into one registered request.
// Latency: entry accepted in cycle N is presented with req_val_o in cycle N+2 (idle slot, no contention).
// Backpressure: req_rdy_i low holds the output slot; FIFOs fill and *_req_rdy_o drop when full.
//
// Ports: clk_i/rst_ni clock and async active-low reset;
//        alloc_req_* / free_req_* upstream valid/ready entry streams;
//        req_val_o/req_rdy_i/req_op_o/req_data_o merged downstream stream;
//        alloc_cnt_o/free_cnt_o registered FIFO occupancies.
module falafel_req_arbiter
  import falafel_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          alloc_req_val_i,
  output logic          alloc_req_rdy_o,
  input  alloc_entry_t  alloc_req_data_i,
  input  logic          free_req_val_i,
  output logic          free_req_rdy_o,
  input  alloc_entry_t  free_req_data_i,
  output logic          req_val_o,
  input  logic          req_rdy_i,
  output req_op_e       req_op_o,
  output alloc_entry_t  req_data_o,
  output logic [CW-1:0] alloc_cnt_o,
  output logic [CW-1:0] free_cnt_o
);

  alloc_entry_t alloc_head;
  alloc_entry_t free_head;
  logic         alloc_full;
  logic         free_full;
  logic         alloc_empty;
  logic         free_empty;
  logic         alloc_pop;
  logic         free_pop;
  logic         slot_open;
  logic         grant_alloc;
  logic         grant_free;
  req_op_e      last_op;

  assign alloc_req_rdy_o = !alloc_full;
  assign free_req_rdy_o  = !free_full;

  falafel_fifo #(
    .DEPTH (DEPTH),
    .T     (alloc_entry_t)
  ) u_alloc_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (alloc_req_val_i),
    .din    (alloc_req_data_i),
    .pop    (alloc_pop),
    .head   (alloc_head),
    .full   (alloc_full),
    .empty  (alloc_empty),
    .cnt    (alloc_cnt_o)
  );

  falafel_fifo #(
    .DEPTH (DEPTH),
    .T     (alloc_entry_t)
  ) u_free_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (free_req_val_i),
    .din    (free_req_data_i),
    .pop    (free_pop),
    .head   (free_head),
    .full   (free_full),
    .empty  (free_empty),
    .cnt    (free_cnt_o)
  );

  // Slot can take a new entry when idle or when its current one leaves this cycle.
  assign slot_open = !req_val_o || req_rdy_i;

  // On contention the op opposite to the last grant wins; otherwise the only
  // non-empty queue wins.
  always_comb begin
    grant_alloc = 1'b0;
    grant_free  = 1'b0;
    if (!alloc_empty && !free_empty) begin
      grant_alloc = (last_op == OP_FREE);
      grant_free  = (last_op == OP_ALLOC);
    end else begin
      grant_alloc = !alloc_empty;
      grant_free  = !free_empty;
    end
  end

  assign alloc_pop = slot_open && grant_alloc;
  assign free_pop  = slot_open && grant_free;

  // Output slot; op/data only change on a load, so they stay put under backpressure.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_val_o  <= 1'b0;
      req_op_o   <= OP_ALLOC;
      req_data_o <= '0;
      last_op    <= OP_FREE;
    end else if (slot_open) begin
      if (alloc_pop) begin
        req_val_o  <= 1'b1;
        req_op_o   <= OP_ALLOC;
        req_data_o <= alloc_head;
        last_op    <= OP_ALLOC;
      end else if (free_pop) begin
        req_val_o  <= 1'b1;
        req_op_o   <= OP_FREE;
        req_data_o <= free_head;
        last_op    <= OP_FREE;
      end else begin
        req_val_o  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_falafel_req_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
// Latency: n/a.
// Backpressure: n/a.
module tb_falafel_req_arbiter;
  import falafel_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          alloc_req_val_i;
  logic          alloc_req_rdy_o;
  alloc_entry_t  alloc_req_data_i;
  logic          free_req_val_i;
  logic          free_req_rdy_o;
  alloc_entry_t  free_req_data_i;
  logic          req_val_o;
  logic          req_rdy_i;
  req_op_e       req_op_o;
  alloc_entry_t  req_data_o;
  logic [CW-1:0] alloc_cnt_o;
  logic [CW-1:0] free_cnt_o;

  always #5 clk_i = ~clk_i;

  falafel_req_arbiter #(.DEPTH(DEPTH)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .alloc_req_val_i  (alloc_req_val_i),
    .alloc_req_rdy_o  (alloc_req_rdy_o),
    .alloc_req_data_i (alloc_req_data_i),
    .free_req_val_i   (free_req_val_i),
    .free_req_rdy_o   (free_req_rdy_o),
    .free_req_data_i  (free_req_data_i),
    .req_val_o        (req_val_o),
    .req_rdy_i        (req_rdy_i),
    .req_op_o         (req_op_o),
    .req_data_o       (req_data_o),
    .alloc_cnt_o      (alloc_cnt_o),
    .free_cnt_o       (free_cnt_o)
  );

  typedef struct packed {
    req_op_e      op;
    alloc_entry_t d;
  } out_t;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: two queues, one output slot, last granted op.
  alloc_entry_t aq[$];
  alloc_entry_t fq[$];
  logic         m_vld;
  req_op_e      m_op;
  alloc_entry_t m_dat;
  req_op_e      m_last;
  out_t         olog[$];

  function automatic alloc_entry_t ent(input int id, input int sz);
    alloc_entry_t e;
    e.id   = MSG_ID_SIZE'(id);
    e.size = DATA_W'(sz);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    aq.delete();
    fq.delete();
    m_vld  = 1'b0;
    m_op   = OP_ALLOC;
    m_dat  = '0;
    m_last = OP_FREE;
  endtask

  // Next-state of the model from the current inputs, applied at the coming edge.
  task automatic model_step();
    bit a_acc;
    bit f_acc;
    bit take_a;
    bit take_f;
    a_acc = alloc_req_val_i && (aq.size() < DEPTH);
    f_acc = free_req_val_i  && (fq.size() < DEPTH);
    if (!m_vld || req_rdy_i) begin
      take_a = 0;
      take_f = 0;
      if (aq.size() > 0 && fq.size() > 0) begin
        if (m_last == OP_FREE) take_a = 1; else take_f = 1;
      end else if (aq.size() > 0) take_a = 1;
      else if (fq.size() > 0) take_f = 1;
      if (take_a) begin
        m_vld = 1; m_op = OP_ALLOC; m_dat = aq.pop_front(); m_last = OP_ALLOC;
      end else if (take_f) begin
        m_vld = 1; m_op = OP_FREE; m_dat = fq.pop_front(); m_last = OP_FREE;
      end else begin
        m_vld = 0;
      end
    end
    if (a_acc) aq.push_back(alloc_req_data_i);
    if (f_acc) fq.push_back(free_req_data_i);
  endtask

  task automatic check_all();
    chk("val",  32'(req_val_o), 32'(m_vld));
    chk("op",   32'(req_op_o), 32'(m_op));
    chk("data", 32'(req_data_o), 32'(m_dat));
    chk("acnt", 32'(alloc_cnt_o), 32'(aq.size()));
    chk("fcnt", 32'(free_cnt_o), 32'(fq.size()));
    chk("ardy", 32'(alloc_req_rdy_o), 32'(aq.size() != DEPTH));
    chk("frdy", 32'(free_req_rdy_o), 32'(fq.size() != DEPTH));
  endtask

  // Called at a negedge with inputs set: log handshake, advance model, check after edge.
  task automatic step();
    if (req_val_o && req_rdy_i) olog.push_back('{req_op_o, req_data_o});
    model_step();
    @(posedge clk_i);
    @(negedge clk_i);
    check_all();
  endtask

  task automatic idle_inputs();
    alloc_req_val_i  = 0;
    free_req_val_i   = 0;
    alloc_req_data_i = '0;
    free_req_data_i  = '0;
  endtask

  task automatic do_reset();
    rst_ni = 0;
    idle_inputs();
    req_rdy_i = 0;
    model_reset();
    repeat (2) @(negedge clk_i);
    rst_ni = 1;
    olog.delete();
  endtask

  task automatic chk_log(input string tag, input int n, input out_t exp[8]);
    chk({tag, "_len"}, 32'(olog.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (i < olog.size()) chk({tag, "_item"}, 32'(olog[i]), 32'(exp[i]));
    end
  endtask

  initial begin
    out_t exp_log[8];

    // Reset values
    do_reset();
    chk("rst_val",  32'(req_val_o), 32'd0);
    chk("rst_op",   32'(req_op_o), 32'(OP_ALLOC));
    chk("rst_data", 32'(req_data_o), 32'd0);
    chk("rst_acnt", 32'(alloc_cnt_o), 32'd0);
    chk("rst_fcnt", 32'(free_cnt_o), 32'd0);
    chk("rst_ardy", 32'(alloc_req_rdy_o), 32'd1);
    chk("rst_frdy", 32'(free_req_rdy_o), 32'd1);

    // Single alloc: visible in FIFO at N+1, presented at N+2
    req_rdy_i = 1;
    alloc_req_val_i = 1; alloc_req_data_i = ent(3, 64);
    step();
    chk("single_cnt1", 32'(alloc_cnt_o), 32'd1);
    chk("single_val1", 32'(req_val_o), 32'd0);
    idle_inputs();
    step();
    chk("single_val2", 32'(req_val_o), 32'd1);
    chk("single_op2",  32'(req_op_o), 32'(OP_ALLOC));
    chk("single_dat2", 32'(req_data_o), 32'(ent(3, 64)));
    chk("single_cnt2", 32'(alloc_cnt_o), 32'd0);
    step();

    // Round-robin: first tie goes to alloc
    do_reset();
    alloc_req_val_i = 1; alloc_req_data_i = ent(1, 1);
    free_req_val_i  = 1; free_req_data_i  = ent(10, 10);
    step();
    alloc_req_data_i = ent(2, 2);
    free_req_data_i  = ent(11, 11);
    step();
    idle_inputs();
    step();
    req_rdy_i = 1;
    repeat (6) step();
    exp_log[0] = '{OP_ALLOC, ent(1, 1)};
    exp_log[1] = '{OP_FREE,  ent(10, 10)};
    exp_log[2] = '{OP_ALLOC, ent(2, 2)};
    exp_log[3] = '{OP_FREE,  ent(11, 11)};
    chk_log("rr", 4, exp_log);

    // Full FIFO: slot parked on a free entry, then 5 alloc pushes
    do_reset();
    free_req_val_i = 1; free_req_data_i = ent(5, 5);
    step();
    idle_inputs();
    step();
    for (int i = 0; i < 5; i++) begin
      alloc_req_val_i = 1; alloc_req_data_i = ent(40 + i, i);
      step();
      chk("full_cnt", 32'(alloc_cnt_o), 32'((i < 4) ? i + 1 : 4));
      chk("full_rdy", 32'(alloc_req_rdy_o), 32'(i < 3));
    end
    idle_inputs();
    req_rdy_i = 1;
    repeat (8) step();
    exp_log[0] = '{OP_FREE, ent(5, 5)};
    for (int i = 0; i < 4; i++) exp_log[i + 1] = '{OP_ALLOC, ent(40 + i, i)};
    chk_log("full", 5, exp_log);

    // Stable under backpressure while the free FIFO fills
    do_reset();
    alloc_req_val_i = 1; alloc_req_data_i = ent(7, 77);
    step();
    idle_inputs();
    step();
    for (int i = 0; i < 5; i++) begin
      free_req_val_i = 1; free_req_data_i = ent(50 + i, i);
      step();
      chk("hold_val", 32'(req_val_o), 32'd1);
      chk("hold_op",  32'(req_op_o), 32'(OP_ALLOC));
      chk("hold_dat", 32'(req_data_o), 32'(ent(7, 77)));
    end
    idle_inputs();
    req_rdy_i = 1;
    step();
    chk("hold_hs_len", 32'(olog.size()), 32'd1);
    repeat (6) step();

    // Streaming: one per cycle, occupancy never above 1
    do_reset();
    req_rdy_i = 1;
    for (int i = 0; i < 13; i++) begin
      alloc_req_val_i = (i < 10);
      alloc_req_data_i = ent(20 + i, 100 + i);
      step();
      chk("stream_cnt", 32'(alloc_cnt_o <= 1), 32'd1);
    end
    chk("stream_len", 32'(olog.size()), 32'd10);
    for (int i = 0; i < 10; i++) begin
      if (i < olog.size()) chk("stream_id", 32'(olog[i].d.id), 32'(20 + i));
    end

    // Reset mid-stream: 3 queued plus valid slot
    do_reset();
    for (int i = 0; i < 4; i++) begin
      alloc_req_val_i = 1; alloc_req_data_i = ent(60 + i, i);
      step();
    end
    idle_inputs();
    chk("mid_pre_val", 32'(req_val_o), 32'd1);
    chk("mid_pre_cnt", 32'(alloc_cnt_o), 32'd3);
    rst_ni = 0;
    #1;
    chk("mid_rst_val",  32'(req_val_o), 32'd0);
    chk("mid_rst_acnt", 32'(alloc_cnt_o), 32'd0);
    chk("mid_rst_fcnt", 32'(free_cnt_o), 32'd0);
    model_reset();
    @(negedge clk_i);
    rst_ni = 1;
    req_rdy_i = 1;
    olog.delete();
    repeat (4) step();
    chk("mid_no_stale", 32'(olog.size()), 32'd0);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      alloc_req_val_i  = 1'($urandom_range(0, 1));
      free_req_val_i   = 1'($urandom_range(0, 1));
      alloc_req_data_i = alloc_entry_t'($urandom);
      free_req_data_i  = alloc_entry_t'($urandom);
      req_rdy_i        = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/falafel_req_arbiter.md
# falafel_req_arbiter

Request queueing and arbitration stage between `falafel_input_parser` and the allocator core. It buffers parsed alloc and free entries in two independent FIFOs and merges them into one request stream tagged with its operation. When both queues are non-empty it alternates between them (round-robin). The output is registered and follows a valid/ready handshake.

## Interface
Parameters:
- `DEPTH`, default 4: entries per FIFO; power of two, ≥ 2.

Ports:
- `clk_i`, in, 1: clock; all logic on the rising edge.
- `rst_ni`, in, 1: reset, asynchronous, active-low.
- `alloc_req_val_i`, in, 1: alloc entry valid.
- `alloc_req_rdy_o`, out, 1: alloc FIFO can accept.
- `alloc_req_data_i`, in, `alloc_entry_t`: alloc entry, with fields `id` (MSG_ID_SIZE bits) and `size` (DATA_W bits).
- `free_req_val_i`, in, 1: free entry valid.
- `free_req_rdy_o`, out, 1: free FIFO can accept.
- `free_req_data_i`, in, `alloc_entry_t`: free entry.
- `req_val_o`, out, 1: merged request valid.
- `req_rdy_i`, in, 1: downstream ready.
- `req_op_o`, out, `req_op_e`: `OP_ALLOC` or `OP_FREE`.
- `req_data_o`, out, `alloc_entry_t`: merged request payload.
- `alloc_cnt_o`, out, `$clog2(DEPTH+1)`: alloc FIFO occupancy.
- `free_cnt_o`, out, `$clog2(DEPTH+1)`: free FIFO occupancy.

## Operation
- **Input side.** Each FIFO pushes on `val_i && rdy_o`. `rdy_o = (cnt != DEPTH)`, taken from registered state only. There is no combinational path from any input to `rdy_o`.
- **Output slot.** A single register holds `valid`, `op` and `data`.
  - The slot loads when it is empty, or when `req_val_o && req_rdy_i` in the same cycle.
  - The slot loads from the winning FIFO head, and that FIFO pops in the same cycle.
- **Arbitration.** A `last_op` register records the last op granted.
  - Only one FIFO non-empty: that FIFO wins.
  - Both FIFOs non-empty: the op opposite to `last_op` wins.
  - Neither non-empty: no load; the slot goes invalid if it was consumed this cycle.
  - `last_op` updates only on a load.
- **Ordering.** Order within each op is FIFO. There is no ordering guarantee between the two ops beyond the round-robin rule.
- **Held output.** While `req_val_o && !req_rdy_i`, `req_op_o` and `req_data_o` hold stable.
- **FIFO bookkeeping.**
  - Read and write pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH.
  - The count updates by +1 on push only, −1 on pop only, and is unchanged on simultaneous push and pop.
  - Simultaneous push and pop on an empty FIFO is impossible, because pop requires non-empty registered state.
  - Push is blocked while full, even if a pop occurs in the same cycle.
- **Reset values.** `req_val_o=0`, `req_op_o=OP_ALLOC`, `req_data_o='0`, both counts 0, both `rdy_o=1`, `last_op=OP_FREE` (so the first tie goes to alloc), all pointers 0.
- **Reset asserted mid-operation.** All state clears immediately (asynchronous); queued and in-flight entries are discarded.

## Timing
- **Latency.** An entry accepted in cycle N is visible in the FIFO at N+1, loaded into the slot at the end of N+1, and presented with `req_val_o=1` in cycle N+2, given an empty slot and no competing head.
- **Throughput.** With `req_rdy_i` held high, one request per cycle.
- **Backpressure.** With `req_rdy_i` low, the FIFOs fill. `rdy_o` drops in the cycle after the DEPTH-th push.
- **Counts.** `alloc_cnt_o` and `free_cnt_o` are registered and reflect state after the previous edge.

## Structure
- **Package.** `falafel_pkg` holds `alloc_entry_t`, `DATA_W`, `MSG_ID_SIZE`, and the new `typedef enum logic {OP_ALLOC=1'b0, OP_FREE=1'b1} req_op_e`.
- **Sub-module.** `falafel_fifo`: a generic synchronous FIFO parameterised by DEPTH and payload type, exposing `push`, `pop`, `head`, `full`, `empty`, `cnt`. It is instantiated twice; arbitration and the output slot live in the top module.

## Test plan
- **Single alloc.** Reset, push alloc {id=3, size=64} at cycle 0 → `req_val_o=1`, `op=OP_ALLOC`, `data={3,64}` at cycle 2; `alloc_cnt_o` reads 1 at cycle 1 and 0 at cycle 2.
- **Round-robin.** Hold `req_rdy_i=0`, push alloc ids 1,2 and free ids 10,11, then raise `req_rdy_i` → output order A1, F10, A2, F11.
- **Full FIFO.** Hold `req_rdy_i=0`, push 5 allocs with DEPTH=4 → `alloc_req_rdy_o=0` after the 4th push, the 5th is not accepted, and `alloc_cnt_o` stays at 4.
- **Stable under backpressure.** Output valid with `req_rdy_i=0` for 5 cycles while the free FIFO fills → `req_op_o` and `req_data_o` are unchanged until the handshake.
- **Streaming.** Continuous alloc pushes with `req_rdy_i=1` → one output per cycle, `alloc_cnt_o` ≤ 1, ids in order.
- **Reset mid-stream.** Assert `rst_ni=0` with 3 entries queued and the slot valid → `req_val_o=0` and counts 0 immediately; after release, no stale entry appears.
